data_mem_responder: RTL and testbench

//  Responder side of the datapath load/store port: a 64-bit word data memory that serves one request at a time.

---
 rtl/data_mem_responder_if.sv | 32 +++
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 tb/tb_data_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//   Request/response bundle between the core's memory-access stage (master)
//   and the data memory responder (slave). Both channels use valid/ready.
//
//   Request channel  : req_valid, req_ready, req_write, req_addr[63:0],
//                      req_wdata[63:0], req_wstrb[7:0]
//   Response channel : rsp_valid, rsp_ready, rsp_rdata[63:0], rsp_err
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   64-bit-word data memory serving one load/store at a time with a fixed
//   access latency. Byte-strobed stores; out-of-range requests return
//   rsp_err=1 with rsp_rdata=0 and never write the array.
//
//   Parameters
//     DEPTH    number of 64-bit words (power of two); byte range 0..DEPTH*8-1
//     LATENCY  wait cycles between accept and access (0..15)
//
//   Ports
//     clk    in   clock, all state on the rising edge
//     reset  in   asynchronous, active-high reset
//     bus    slave modport of data_mem_responder_if (request + response)
//
//   Configuration
//     DMEM_MISALIGN_TRAP_EN  defined: a non-zero req_addr[2:0] is an error.
//                            undefined: the address is aligned down silently.
//
//   Sequence: IDLE (accept) -> BUSY (LATENCY+1 cycles, access on last edge)
//             -> RESP (hold until rsp_ready) -> IDLE.
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int          IDX_W      = $clog2(DEPTH);
    // Byte address >= DEPTH*8 is the same as word address >= DEPTH.
    localparam logic [60:0] WORD_LIMIT = 61'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [60:0] word_q;     // req_addr[63:3], captured at accept
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;

    logic [63:0] mem [0:DEPTH-1];

    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic             do_store;

    assign idx = word_q[IDX_W-1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign_q;
    assign acc_err = (word_q >= WORD_LIMIT) || misalign_q;
`else
    // Byte offset within the word carries no meaning when alignment is not trapped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus.req_addr[2:0];
    assign acc_err = (word_q >= WORD_LIMIT);
`endif

    // The access happens on the last BUSY edge; state is forced to IDLE while
    // reset is high, so a store in flight during reset is dropped.
    assign do_store = (state == BUSY) && (cnt == 4'd0) && wr_q && !acc_err;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            wr_q          <= 1'b0;
            word_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is high throughout IDLE, so req_valid alone is the handshake.
                    if (bus.req_valid) begin
                        wr_q          <= bus.req_write;
                        word_q        <= bus.req_addr[63:3];
                        wdata_q       <= bus.req_wdata;
                        wstrb_q       <= bus.req_wstrb;
`ifdef DMEM_MISALIGN_TRAP_EN
                        misalign_q    <= |bus.req_addr[2:0];
`endif
                        cnt           <= 4'(LATENCY);
                        bus.req_ready <= 1'b0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= acc_err;
                        bus.rsp_rdata <= (acc_err || wr_q) ? 64'd0 : mem[idx];
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // rdata/err are left untouched here so they stay stable under stall.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array has no reset; it maps onto RAM, and the reset state of
    // memory contents is undefined by design.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder (DEPTH=1024, LATENCY=2).
//   Expected responses come from a reference memory model and are queued
//   when a request is driven, then popped when the DUT responds.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic clk;
    logic reset;

    data_mem_responder_if bus_if ();

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] model_mem [0:DEPTH-1];

    int n_asserts = 0;
    int n_fail    = 0;

    function automatic logic exp_err(input logic [63:0] a);
        logic e;
        e = (a >= 64'(DEPTH) * 64'd8);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a[2:0] != 3'd0) e = 1'b1;
`endif
        return e;
    endfunction

    // Update the reference model and queue the expected response.
    task automatic push_expect(input logic wr, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wstrb);
        exp_t e;
        int   w;
        w       = int'(addr[12:3]);
        e.err   = exp_err(addr);
        e.rdata = 64'd0;
        if (!e.err) begin
            if (wr) begin
                for (int i = 0; i < 8; i++)
                    if (wstrb[i]) model_mem[w][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                e.rdata = model_mem[w];
            end
        end
        sb.push_back(e);
    endtask

    // Entered and left at posedge+1. Returns just after the accept edge.
    task automatic send_req(input logic wr, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wstrb,
                            input bit track);
        int budget;
        budget = 0;
        if (track) push_expect(wr, addr, wdata, wstrb);
        bus_if.req_write = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_wstrb = wstrb;
        bus_if.req_valid = 1'b1;
        while (bus_if.req_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        n_asserts++;
        if (budget >= 50) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus_if.req_ready, budget);
        end
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        // Scramble the request bus: the DUT must have sampled it at the accept edge.
        bus_if.req_write = 1'($urandom);
        bus_if.req_addr  = {$urandom, $urandom};
        bus_if.req_wdata = {$urandom, $urandom};
        bus_if.req_wstrb = 8'($urandom);
        n_asserts++;
        if (bus_if.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL req_ready_after_accept: got %b, required 0", bus_if.req_ready);
        end
    endtask

    // Entered just after the accept edge. Waits for the response, checks
    // latency and payload, stalls for 'stall' cycles, then completes the handshake.
    task automatic recv_rsp(input int stall, input string name);
        int          cyc;
        logic [63:0] rd;
        logic        er;
        exp_t        e;
        cyc = 0;
        while (bus_if.rsp_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_asserts++;
        if (cyc != LATENCY + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, LATENCY + 1);
        end
        rd = bus_if.rsp_rdata;
        er = bus_if.rsp_err;
        n_asserts++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: response with no expectation queued", name);
        end else begin
            e = sb.pop_front();
            if (rd !== e.rdata) begin
                n_fail++;
                $display("FAIL %s rdata: got %h, required %h", name, rd, e.rdata);
            end
            n_asserts++;
            if (er !== e.err) begin
                n_fail++;
                $display("FAIL %s err: got %b, required %b", name, er, e.err);
            end
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            n_asserts++;
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== rd ||
                bus_if.rsp_err !== er || bus_if.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall[%0d]: valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                         name, s, bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err,
                         bus_if.req_ready, rd, er);
            end
        end
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
        n_asserts++;
        if (bus_if.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rsp_valid_after_handshake: got %b, required 0", name, bus_if.rsp_valid);
        end
        n_asserts++;
        if (bus_if.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_ready_after_handshake: got %b, required 1", name, bus_if.req_ready);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_asserts++;
        if (bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0 ||
            bus_if.rsp_rdata !== 64'd0 || bus_if.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: req_ready=%b rsp_valid=%b rdata=%h err=%b, required 1 0 0 0",
                     name, bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset_released");
        // Assert reset between edges; the async path must act immediately.
        #3 reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_cycle");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset_mid_released");
    endtask

    task automatic test_store_load();
        send_req(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 1'b1);
        recv_rsp(0, "store_full");
        send_req(1'b0, 64'h10, 64'h0, 8'h00, 1'b1);
        recv_rsp(0, "load_full");
    endtask

    task automatic test_byte_strobe();
        send_req(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1);
        recv_rsp(0, "store_strb0f");
        send_req(1'b0, 64'h10, 64'h0, 8'hFF, 1'b1);
        recv_rsp(0, "load_strb0f");
        // wstrb=0 is a legal no-op store.
        send_req(1'b1, 64'h10, 64'h5555555555555555, 8'h00, 1'b1);
        recv_rsp(0, "store_strb00");
        send_req(1'b0, 64'h10, 64'h0, 8'h00, 1'b1);
        recv_rsp(0, "load_strb00");
        // Alternating strobe pattern on another word.
        send_req(1'b1, 64'h48, 64'h0123456789ABCDEF, 8'hFF, 1'b1);
        recv_rsp(0, "store_48");
        send_req(1'b1, 64'h48, 64'hFFFFFFFFFFFFFFFF, 8'hA5, 1'b1);
        recv_rsp(0, "store_48_a5");
        send_req(1'b0, 64'h48, 64'h0, 8'h00, 1'b1);
        recv_rsp(0, "load_48");
    endtask

    task automatic test_back_pressure();
        send_req(1'b0, 64'h10, 64'h0, 8'h00, 1'b1);
        // Offer the next request immediately; it must wait until after the handshake.
        push_expect(1'b0, 64'h48, 64'h0, 8'h00);
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 64'h48;
        bus_if.req_wdata = 64'h0;
        bus_if.req_wstrb = 8'h00;
        bus_if.req_valid = 1'b1;
        recv_rsp(5, "stall_load");
        @(posedge clk); #1;
        n_asserts++;
        if (bus_if.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_accept: req_ready=%b, required 0 one cycle after handshake", bus_if.req_ready);
        end
        bus_if.req_valid = 1'b0;
        recv_rsp(0, "pending_load");
    endtask

    task automatic test_range();
        send_req(1'b1, 64'h1FF8, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
        recv_rsp(0, "store_last_word");
        send_req(1'b1, 64'h2000, 64'h0BADC0DE0BADC0DE, 8'hFF, 1'b1);
        recv_rsp(0, "store_oor");
        send_req(1'b0, 64'h1FF8, 64'h0, 8'h00, 1'b1);
        recv_rsp(0, "load_last_word");
        send_req(1'b0, 64'hFFFF_0000_0000_0010, 64'h0, 8'h00, 1'b1);
        recv_rsp(2, "load_oor_high");
        send_req(1'b0, 64'h13, 64'h0, 8'h00, 1'b1);
        recv_rsp(0, "load_misaligned");
        send_req(1'b1, 64'h15, 64'h7777777777777777, 8'hFF, 1'b1);
        recv_rsp(0, "store_misaligned");
        send_req(1'b0, 64'h10, 64'h0, 8'h00, 1'b1);
        recv_rsp(0, "load_after_misaligned_store");
    endtask

    task automatic test_reset_in_busy();
        bit saw_rsp;
        send_req(1'b1, 64'h20, 64'hCAFEBABE12345678, 8'hFF, 1'b1);
        recv_rsp(0, "store_20_prior");
        // Untracked store: it is dropped by the reset pulse.
        send_req(1'b1, 64'h20, 64'h9999999999999999, 8'hFF, 1'b0);
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        saw_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus_if.rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        n_asserts++;
        if (saw_rsp) begin
            n_fail++;
            $display("FAIL reset_busy_no_rsp: rsp_valid seen high, required 0");
        end
        check_idle_outputs("reset_busy_idle");
        send_req(1'b0, 64'h20, 64'h0, 8'h00, 1'b1);
        recv_rsp(0, "load_20_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 64'h0;
        bus_if.req_wdata = 64'h0;
        bus_if.req_wstrb = 8'h00;
        bus_if.rsp_ready = 1'b0;

        test_reset();
        test_store_load();
        test_byte_strobe();
        test_back_pressure();
        test_range();
        test_reset_in_busy();

        n_asserts++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
